nfc_status_poller: RTL and testbench

NFC_STATUS_POLLER -- requirements
Module: nfc_status_poller

---
 rtl/nfc_status_poller_if.sv | 39 +++
 rtl/nfc_status_poller.sv | 143 ++++++++++++++
 tb/tb_nfc_status_poller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_status_poller_if.sv
// rtl/nfc_status_poller_if.sv - poll request/result and read-status executor signals of the status poller
interface nfc_status_poller_if #(
    parameter int NumberOfWays = 4
);
    logic                    iPollValid;
    logic                    oPollReady;
    logic [NumberOfWays-1:0] iPollWay;
    logic [23:0]             iPollRow;
    logic                    iPollEnhanced;
    logic                    oDone;
    logic                    oReady;
    logic                    oFail;
    logic                    oTimeout;
    logic [7:0]              oStatusByte;
    logic [15:0]             oPollCount;
    logic [5:0]              oRS_Opcode;
    logic [4:0]              oRS_TargetID;
    logic                    oRS_CMDValid;
    logic                    iRS_CMDReady;
    logic [NumberOfWays-1:0] oRS_WaySelect;
    logic [23:0]             oRS_RowAddress;
    logic                    iRS_LastStep;
    logic [23:0]             iRS_Status;
    logic                    iRS_StatusValid;

    modport slave (
        input  iPollValid, iPollWay, iPollRow, iPollEnhanced,
        input  iRS_CMDReady, iRS_LastStep, iRS_Status, iRS_StatusValid,
        output oPollReady, oDone, oReady, oFail, oTimeout, oStatusByte, oPollCount,
        output oRS_Opcode, oRS_TargetID, oRS_CMDValid, oRS_WaySelect, oRS_RowAddress
    );

    modport master (
        output iPollValid, iPollWay, iPollRow, iPollEnhanced,
        output iRS_CMDReady, iRS_LastStep, iRS_Status, iRS_StatusValid,
        input  oPollReady, oDone, oReady, oFail, oTimeout, oStatusByte, oPollCount,
        input  oRS_Opcode, oRS_TargetID, oRS_CMDValid, oRS_WaySelect, oRS_RowAddress
    );
endinterface

// File: rtl/nfc_status_poller.sv
// rtl/nfc_status_poller.sv - repeats NAND read-status commands until SR[6] is set or the poll budget runs out
module nfc_status_poller #(
    parameter int          NumberOfWays    = 4,
    parameter logic [5:0]  StatusCommandID = 6'b000111,
    parameter logic [15:0] MaxPolls        = 16'd1000,
    parameter logic [7:0]  PollInterval    = 8'd16
) (
    input  logic               iSystemClock,
    input  logic               iReset,
    nfc_status_poller_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [NumberOfWays-1:0] way_q;
    logic [23:0]             row_q;
    logic                    enh_q;
    logic [15:0]             poll_count;
    logic [7:0]              status_byte;
    logic [7:0]              gap_count;
    logic                    ready_q;
    logic                    fail_q;
    logic                    timeout_q;
    logic                    poll_ready;
    logic                    cmd_valid;
    logic                    done_pulse;
    logic [15:0]             unused_status_hi;

    assign unused_status_hi = bus.iRS_Status[23:8];

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        poll_ready = 1'b0;
        cmd_valid  = 1'b0;
        done_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                poll_ready = 1'b1;
                if (bus.iPollValid) next_state = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_valid = 1'b1;
                if (bus.iRS_CMDReady) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.iRS_LastStep) next_state = S_EVAL;
            end
            S_EVAL: begin
                if (status_byte[6] || (poll_count == MaxPolls)) next_state = S_DONE;
                else next_state = S_GAP;
            end
            S_GAP: begin
                if (gap_count == 8'd0) next_state = S_ISSUE;
            end
            S_DONE: begin
                done_pulse = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // A poll starts from a zero byte so a LastStep without any StatusValid reads as not ready.
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            way_q       <= '0;
            row_q       <= '0;
            enh_q       <= 1'b0;
            poll_count  <= '0;
            status_byte <= '0;
            gap_count   <= '0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.iPollValid) begin
                        way_q      <= bus.iPollWay;
                        row_q      <= bus.iPollRow;
                        enh_q      <= bus.iPollEnhanced;
                        poll_count <= '0;
                        ready_q    <= 1'b0;
                        fail_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    status_byte <= '0;
                    if (bus.iRS_CMDReady) poll_count <= poll_count + 16'd1;
                end
                S_WAIT: begin
                    if (bus.iRS_StatusValid) status_byte <= bus.iRS_Status[7:0];
                end
                S_EVAL: begin
                    if (status_byte[6]) begin
                        ready_q <= 1'b1;
                        fail_q  <= status_byte[0];
                    end else if (poll_count == MaxPolls) begin
                        timeout_q <= 1'b1;
                    end else begin
                        gap_count <= PollInterval;
                    end
                end
                S_GAP: begin
                    if (gap_count != 8'd0) gap_count <= gap_count - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oPollReady     = poll_ready;
    assign bus.oDone          = done_pulse;
    assign bus.oReady         = ready_q;
    assign bus.oFail          = fail_q;
    assign bus.oTimeout       = timeout_q;
    assign bus.oStatusByte    = status_byte;
    assign bus.oPollCount     = poll_count;
    assign bus.oRS_Opcode     = StatusCommandID;
    assign bus.oRS_TargetID   = {4'b0000, enh_q};
    assign bus.oRS_CMDValid   = cmd_valid;
    assign bus.oRS_WaySelect  = way_q;
    assign bus.oRS_RowAddress = row_q;

endmodule

// File: tb/tb_nfc_status_poller.sv
// tb/tb_nfc_status_poller.sv - randomized self-checking bench for nfc_status_poller
module tb_nfc_status_poller;
    localparam int         WAYS = 4;
    localparam int         MAXP = 4;
    localparam int         PINT = 16;
    localparam logic [5:0] OPC  = 6'b000111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    bit         plan_has[MAXP];
    logic [7:0] plan_byte[MAXP];
    bit         plan_coinc[MAXP];
    bit         plan_junk[MAXP];

    always #5 clk = ~clk;

    nfc_status_poller_if #(.NumberOfWays(WAYS)) bus ();

    nfc_status_poller #(
        .NumberOfWays   (WAYS),
        .StatusCommandID(OPC),
        .MaxPolls       (16'(MAXP)),
        .PollInterval   (8'(PINT))
    ) dut (
        .iSystemClock(clk),
        .iReset      (rst),
        .bus         (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [63:0] other_outs();
        return {bus.oDone, bus.oReady, bus.oFail, bus.oTimeout, bus.oStatusByte, bus.oPollCount,
                bus.oRS_TargetID, bus.oRS_CMDValid, bus.oRS_WaySelect, bus.oRS_RowAddress};
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < MAXP; i++) begin
            plan_has[i]   = 1'b1;
            plan_byte[i]  = 8'h80;
            plan_coinc[i] = 1'b0;
            plan_junk[i]  = 1'b0;
        end
    endtask

    task automatic set_plan(input int i, input bit has, input logic [7:0] b, input bit coinc, input bit junk);
        plan_has[i]   = has;
        plan_byte[i]  = b;
        plan_coinc[i] = coinc;
        plan_junk[i]  = junk;
    endtask

    // Reference: the request ends at the first poll whose effective byte has SR[6], else after MAXP polls.
    task automatic run_request(input logic [WAYS-1:0] way, input logic [23:0] row, input logic enh, input int hold);
        int         exp_polls, polls, last_ls, start, idx;
        bit         exp_ready, exp_fail, exp_to, done, hold_ok, bad;
        logic [7:0] exp_byte, eff;
        exp_polls = MAXP;
        exp_ready = 1'b0;
        exp_fail  = 1'b0;
        exp_to    = 1'b1;
        exp_byte  = plan_has[MAXP-1] ? plan_byte[MAXP-1] : 8'h00;
        for (int i = 0; i < MAXP; i++) begin
            eff = plan_has[i] ? plan_byte[i] : 8'h00;
            if (eff[6]) begin
                exp_polls = i + 1;
                exp_ready = 1'b1;
                exp_fail  = eff[0];
                exp_to    = 1'b0;
                exp_byte  = eff;
                break;
            end
        end

        check("poll_ready_idle", bus.oPollReady, 1);
        bus.iPollValid    = 1'b1;
        bus.iPollWay      = way;
        bus.iPollRow      = row;
        bus.iPollEnhanced = enh;
        step();
        bus.iPollValid    = 1'b0;
        bus.iPollWay      = WAYS'($urandom);
        bus.iPollRow      = 24'($urandom);
        bus.iPollEnhanced = 1'($urandom);

        polls   = 0;
        done    = 1'b0;
        last_ls = 0;
        start   = cyc;
        while (!done && (cyc - start) < 4000) begin
            if (bus.oDone) begin
                done = 1'b1;
                check("ready", bus.oReady, exp_ready);
                check("fail", bus.oFail, exp_fail);
                check("timeout", bus.oTimeout, exp_to);
                check("status_byte", bus.oStatusByte, exp_byte);
                check("poll_count", bus.oPollCount, exp_polls);
                check("transfers", polls, exp_polls);
                step();
                check("done_one_cycle", bus.oDone, 0);
                bad = 1'b0;
                repeat (25) begin
                    if (bus.oRS_CMDValid || bus.oDone || !bus.oPollReady) bad = 1'b1;
                    step();
                end
                check("quiet_after_done", bad, 0);
                check("results_held", {bus.oReady, bus.oFail, bus.oTimeout, bus.oStatusByte, bus.oPollCount},
                      {exp_ready, exp_fail, exp_to, exp_byte, 16'(exp_polls)});
            end else if (bus.oRS_CMDValid) begin
                if (polls > 0) check("gap_cycles", cyc - last_ls, PINT + 3);
                if (polls == 0 && hold > 0) begin
                    hold_ok = 1'b1;
                    repeat (hold) begin
                        step();
                        if (!bus.oRS_CMDValid) hold_ok = 1'b0;
                    end
                    check("valid_held", hold_ok, 1);
                    check("count_while_held", bus.oPollCount, 0);
                end
                bus.iRS_CMDReady = 1'b1;
                step();
                bus.iRS_CMDReady = 1'b0;
                polls++;
                idx = (polls <= MAXP) ? polls - 1 : MAXP - 1;
                check("cmd_valid_drop", bus.oRS_CMDValid, 0);
                check("count_on_issue", bus.oPollCount, polls);
                check("latched_issue", {bus.oRS_WaySelect, bus.oRS_RowAddress, bus.oRS_TargetID},
                      {way, row, 4'b0000, enh});
                repeat ($urandom_range(0, 3)) step();
                if (plan_has[idx] && plan_junk[idx]) begin
                    bus.iRS_StatusValid = 1'b1;
                    bus.iRS_Status      = 24'($urandom);
                    step();
                    bus.iRS_StatusValid = 1'b0;
                end
                if (plan_has[idx]) begin
                    bus.iRS_StatusValid = 1'b1;
                    bus.iRS_Status      = {16'($urandom), plan_byte[idx]};
                    if (!plan_coinc[idx]) begin
                        step();
                        bus.iRS_StatusValid = 1'b0;
                        repeat ($urandom_range(0, 2)) step();
                    end
                end
                check("latched_wait", {bus.oRS_WaySelect, bus.oRS_RowAddress, bus.oRS_TargetID, bus.oRS_CMDValid},
                      {way, row, 4'b0000, enh, 1'b0});
                bus.iRS_LastStep = 1'b1;
                last_ls = cyc;
                step();
                bus.iRS_LastStep    = 1'b0;
                bus.iRS_StatusValid = 1'b0;
            end else begin
                step();
            end
        end
        if (!done) check("done_seen", 0, 1);
    endtask

    initial begin
        bus.iPollValid      = 1'b0;
        bus.iPollWay        = '0;
        bus.iPollRow        = '0;
        bus.iPollEnhanced   = 1'b0;
        bus.iRS_CMDReady    = 1'b0;
        bus.iRS_LastStep    = 1'b0;
        bus.iRS_Status      = '0;
        bus.iRS_StatusValid = 1'b0;
        repeat (3) step();
        check("reset_poll_ready", bus.oPollReady, 1);
        check("reset_opcode", bus.oRS_Opcode, OPC);
        check("reset_outputs", other_outs(), 0);
        rst = 1'b0;
        step();

        clear_plan();
        set_plan(0, 1, 8'hE0, 0, 0);
        run_request(4'b0010, 24'hABCDEF, 1'b0, 0);

        clear_plan();
        set_plan(2, 1, 8'hC1, 0, 0);
        run_request(4'b0100, 24'h012345, 1'b1, 0);

        clear_plan();
        run_request(4'b1000, 24'h000777, 1'b0, 0);

        clear_plan();
        set_plan(0, 1, 8'hE0, 0, 0);
        run_request(4'b0001, 24'h100000, 1'b0, 50);

        clear_plan();
        set_plan(0, 1, 8'h40, 1, 0);
        run_request(4'b0010, 24'h00F00F, 1'b1, 0);

        clear_plan();
        set_plan(0, 0, 8'h00, 0, 0);
        set_plan(1, 1, 8'hE0, 0, 1);
        run_request(4'b0001, 24'h55AA55, 1'b0, 0);

        // Reset while the executor is mid-command.
        clear_plan();
        bus.iPollValid = 1'b1;
        bus.iPollWay   = 4'b0100;
        bus.iPollRow   = 24'h0A0B0C;
        step();
        bus.iPollValid   = 1'b0;
        bus.iRS_CMDReady = 1'b1;
        step();
        bus.iRS_CMDReady = 1'b0;
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_poll_ready", bus.oPollReady, 1);
        check("async_rst_opcode", bus.oRS_Opcode, OPC);
        check("async_rst_outputs", other_outs(), 0);
        step();
        rst = 1'b0;
        begin
            bit bad;
            bad = 1'b0;
            repeat (40) begin
                step();
                if (bus.oRS_CMDValid) bad = 1'b1;
            end
            check("no_cmd_after_reset", bad, 0);
        end

        for (int r = 0; r < 14; r++) begin
            logic [WAYS-1:0] w;
            logic [7:0]      b;
            for (int i = 0; i < MAXP; i++) begin
                b    = 8'($urandom);
                b[6] = ($urandom_range(0, 3) == 0);
                set_plan(i, $urandom_range(0, 3) != 0, b, 1'($urandom), 1'($urandom));
            end
            w = WAYS'(1) << $urandom_range(0, WAYS - 1);
            run_request(w, 24'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
